// File: rtl/pingpong_buf_ctrl.sv
// Ping-pong controller for a two-bank feature-map buffer: the producer fills one
// bank while the consumer drains the other, and the banks swap at frame boundaries.
module pingpong_buf_ctrl #(
  parameter int FRAME_LEN = 196,
  parameter int ADDR_W    = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wr_en,
  output logic              wr_ready,
  output logic              wr_we,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_frame_done,
  input  logic              rd_en,
  output logic              rd_ready,
  output logic              rd_re,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic              rd_frame_done,
  output logic [1:0]        bank_full
);

  // Terminal count; FRAME_LEN=256 maps to 8'hFF so the 8-bit counters wrap cleanly.
  localparam logic [7:0] LAST_CNT = 8'(FRAME_LEN - 1);

  logic       wbank;
  logic       rbank;
  logic [7:0] wcnt;
  logic [7:0] rcnt;
  logic       wr_last;
  logic       rd_last;
  logic [1:0] bank_full_nx;
  logic       wr_done_p1;
  logic       rd_vld_p1;
  logic       rd_last_p1;

  // Stage p0: combinational handshakes and bank-tagged addresses
  assign wr_ready = ~bank_full[wbank];
  assign wr_we    = wr_en & wr_ready;
  assign wr_addr  = ADDR_W'({wbank, wcnt});
  assign wr_last  = wr_we & (wcnt == LAST_CNT);

  assign rd_ready = bank_full[rbank];
  assign rd_re    = rd_en & rd_ready;
  assign rd_addr  = ADDR_W'({rbank, rcnt});
  assign rd_last  = rd_re & (rcnt == LAST_CNT);

  // Set and clear never target the same bank, so applying both is order-free.
  always_comb begin
    bank_full_nx = bank_full;
    if (wr_last) bank_full_nx[wbank] = 1'b1;
    if (rd_last) bank_full_nx[rbank] = 1'b0;
  end

  // Stage p1: bank ownership, counters and the registered strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbank      <= 1'b0;
      rbank      <= 1'b0;
      wcnt       <= '0;
      rcnt       <= '0;
      bank_full  <= '0;
      wr_done_p1 <= 1'b0;
      rd_vld_p1  <= 1'b0;
      rd_last_p1 <= 1'b0;
    end else if (flush) begin
      wbank      <= 1'b0;
      rbank      <= 1'b0;
      wcnt       <= '0;
      rcnt       <= '0;
      bank_full  <= '0;
      wr_done_p1 <= 1'b0;
      rd_vld_p1  <= 1'b0;
      rd_last_p1 <= 1'b0;
    end else begin
      if (wr_we) begin
        if (wr_last) begin
          wcnt  <= '0;
          wbank <= ~wbank;
        end else begin
          wcnt <= wcnt + 8'd1;
        end
      end
      if (rd_re) begin
        if (rd_last) begin
          rcnt  <= '0;
          rbank <= ~rbank;
        end else begin
          rcnt <= rcnt + 8'd1;
        end
      end
      bank_full  <= bank_full_nx;
      wr_done_p1 <= wr_last;
      rd_vld_p1  <= rd_re;
      rd_last_p1 <= rd_last;
    end
  end

  assign wr_frame_done = wr_done_p1;
  assign rd_valid      = rd_vld_p1;
  assign rd_frame_done = rd_last_p1;

endmodule
